// File: rtl/iface_item_consumer_if.sv
// Item producer / word consumer bundle: 3-bit item handshake in, packed word handshake out.
interface iface_item_consumer_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PACK  = 4
) ();
    localparam int unsigned WORD_W = 3 * PACK;
    localparam int unsigned LEN_W  = $clog2(PACK + 1);
    localparam int unsigned FILL_W = $clog2(DEPTH) + 1;

    logic              item_valid;
    logic [2:0]        item;
    logic              item_ready;
    logic              flush;
    logic              word_valid;
    logic [WORD_W-1:0] word;
    logic [LEN_W-1:0]  word_len;
    logic              word_ready;
    logic [FILL_W-1:0] fill;

    modport master (
        output item_valid, item, flush, word_ready,
        input  item_ready, word_valid, word, word_len, fill
    );

    modport slave (
        input  item_valid, item, flush, word_ready,
        output item_ready, word_valid, word, word_len, fill
    );
endinterface

// File: rtl/iface_item_consumer.sv
// Buffers 3-bit items in a small FIFO and packs PACK of them per output word,
// with a flush path that emits a partial word once the FIFO has drained.
module iface_item_consumer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PACK  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    iface_item_consumer_if.slave  bus
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;
    localparam int unsigned CNT_W  = $clog2(PACK);
    localparam int unsigned LEN_W  = $clog2(PACK + 1);
    localparam int unsigned WORD_W = 3 * PACK;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    logic [2:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [FILL_W-1:0] r_fill;
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0] r_word;
    logic [LEN_W-1:0]  r_len;

    logic              w_item_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic [2:0]        w_head;
    logic [FILL_W-1:0] w_fill_nxt;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [WORD_W-1:0] w_word_nxt;
    logic [LEN_W-1:0]  w_len_nxt;

    // Ready looks only at the registered occupancy, so a same-cycle pop never frees a slot early.
    assign w_item_ready = rst_n && (r_fill < FILL_W'(DEPTH));
    assign w_push       = bus.item_valid && w_item_ready;
    assign w_empty      = (r_fill == '0);
    assign w_head       = r_mem[r_rptr];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_word_nxt  = r_word;
        w_len_nxt   = r_len;
        w_pop       = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    for (int unsigned s = 0; s < PACK; s++) begin
                        if (CNT_W'(s) == r_cnt) begin
                            w_word_nxt[3*s +: 3] = w_head;
                        end
                    end
                    if (r_cnt == CNT_W'(PACK - 1)) begin
                        w_state_nxt = ST_HOLD;
                        w_len_nxt   = LEN_W'(PACK);
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else if (bus.flush && (r_cnt != '0)) begin
                    w_state_nxt = ST_HOLD;
                    w_len_nxt   = LEN_W'(r_cnt);
                    w_cnt_nxt   = '0;
                end
            end
            ST_HOLD: begin
                if (bus.word_ready) begin
                    w_state_nxt = ST_FILL;
                    w_word_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase
    end

    always_comb begin
        w_fill_nxt = r_fill;
        case ({w_push, w_pop})
            2'b10:   w_fill_nxt = r_fill + FILL_W'(1);
            2'b01:   w_fill_nxt = r_fill - FILL_W'(1);
            default: w_fill_nxt = r_fill;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
            r_cnt   <= '0;
            r_word  <= '0;
            r_len   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_fill  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_word  <= w_word_nxt;
            r_len   <= w_len_nxt;
            r_fill  <= w_fill_nxt;
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
        end
    end

    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= bus.item;
    end

    assign bus.item_ready = w_item_ready;
    assign bus.word_valid = (r_state == ST_HOLD);
    assign bus.word       = r_word;
    assign bus.word_len   = r_len;
    assign bus.fill       = r_fill;
endmodule
